// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port owner: round-robin arbitration of ALU and load/store
// writeback, registered write toward the file, and a drain-then-clear flush sequence.
module regfile_wb_arbiter #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 5,
  parameter int unsigned FIRST_PRIO = 0,
  parameter int unsigned CNT_W      = 16
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              a_valid,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ready,
  input  logic              flush_req,
  output logic              flush_busy,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              rf_clr,
  output logic [CNT_W-1:0]  collision_cnt
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    CLEAR = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  // lp holds the last granted requester (0=A, 1=B); reset to the opposite of FIRST_PRIO
  localparam logic             LP_RESET = (FIRST_PRIO == 0) ? 1'b1 : 1'b0;

  state_e              state_q, state_d;
  logic                lp_q, lp_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   waddr_q, waddr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                clr_q, clr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= RUN;
      lp_q    <= LP_RESET;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      clr_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      lp_q    <= lp_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      clr_q   <= clr_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    lp_d    = lp_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    clr_d   = 1'b0;
    cnt_d   = cnt_q;
    a_ready = 1'b0;
    b_ready = 1'b0;

    case (state_q)
      RUN: begin
        if (flush_req) begin
          state_d = DRAIN;
        end else if (a_valid && b_valid) begin
          if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
          if (lp_q == 1'b0) b_ready = 1'b1;
          else              a_ready = 1'b1;
        end else begin
          a_ready = a_valid;
          b_ready = b_valid;
        end
      end
      DRAIN: begin
        state_d = CLEAR;
        clr_d   = 1'b1;
      end
      CLEAR: begin
        state_d = RUN;
      end
      default: begin
        state_d = RUN;
      end
    endcase

    // Register the granted write; writes to x0 are consumed but never enabled
    if (a_ready) begin
      lp_d    = 1'b0;
      waddr_d = a_addr;
      wdata_d = a_data;
      we_d    = (a_addr != '0);
    end else if (b_ready) begin
      lp_d    = 1'b1;
      waddr_d = b_addr;
      wdata_d = b_data;
      we_d    = (b_addr != '0);
    end
  end

  assign flush_busy    = (state_q != RUN);
  assign rf_we         = we_q;
  assign rf_waddr      = waddr_q;
  assign rf_wdata      = wdata_q;
  assign rf_clr        = clr_q;
  assign collision_cnt = cnt_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: accepted writes are queued with their due
// cycle and a negedge monitor matches them against the register-file port.
module tb_regfile_wb_arbiter;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned CW = 4;

  logic          clk;
  logic          clr;
  logic          a_valid, b_valid, flush_req;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_data, b_data;
  logic          a_ready, b_ready, flush_busy;
  logic          rf_we, rf_clr;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic [CW-1:0] collision_cnt;

  regfile_wb_arbiter #(
    .DATA_W(DW), .ADDR_W(AW), .FIRST_PRIO(0), .CNT_W(CW)
  ) dut (
    .clk(clk), .clr(clr),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
    .flush_req(flush_req), .flush_busy(flush_busy),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rf_clr(rf_clr),
    .collision_cnt(collision_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            due;
  } wr_t;

  wr_t exp_q[$];
  int  vectors     = 0;
  int  miscompares = 0;
  int  cyc_cnt     = 0;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc_cnt);
    end
  endtask

  // Called at the negedge of the accepting cycle; the write is due one edge later
  task automatic expect_write(input logic [AW-1:0] addr, input logic [DW-1:0] data);
    exp_q.push_back('{addr, data, cyc_cnt + 1});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    a_valid   = 1'b0;
    b_valid   = 1'b0;
    flush_req = 1'b0;
  endtask

  task automatic drive_a(input logic [AW-1:0] addr, input logic [DW-1:0] data);
    a_valid = 1'b1;
    a_addr  = addr;
    a_data  = data;
  endtask

  task automatic drive_b(input logic [AW-1:0] addr, input logic [DW-1:0] data);
    b_valid = 1'b1;
    b_addr  = addr;
    b_data  = data;
  endtask

  // Monitor: every cycle either the head write is due on rf_* or rf_we must be low
  always @(negedge clk) begin
    if (exp_q.size() > 0 && exp_q[0].due < cyc_cnt) begin
      check("write_missed", 32'(exp_q[0].addr), 32'hFFFF_FFFF);
      void'(exp_q.pop_front());
    end
    if (exp_q.size() > 0 && exp_q[0].due == cyc_cnt) begin
      check("rf_we", 32'(rf_we), 32'd1);
      check("rf_waddr", 32'(rf_waddr), 32'(exp_q[0].addr));
      check("rf_wdata", rf_wdata, exp_q[0].data);
      void'(exp_q.pop_front());
    end else begin
      check("rf_we_idle", 32'(rf_we), 32'd0);
    end
    check("we_clr_excl", 32'(rf_we & rf_clr), 32'd0);
  end

  initial begin
    logic exp_a;
    clr = 1'b1;
    idle();
    a_addr = '0; a_data = '0; b_addr = '0; b_data = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rf_waddr", 32'(rf_waddr), 32'd0);
    check("rst_rf_wdata", rf_wdata, 32'd0);
    check("rst_rf_clr", 32'(rf_clr), 32'd0);
    check("rst_cnt", 32'(collision_cnt), 32'd0);
    check("rst_busy", 32'(flush_busy), 32'd0);
    clr = 1'b0;

    // Single writes from each requester
    drive_a(5'd4, 32'h7);
    @(negedge clk);
    check("a_ready_single", 32'(a_ready), 32'd1);
    check("b_ready_single_a", 32'(b_ready), 32'd0);
    expect_write(5'd4, 32'h7);
    step();
    a_valid = 1'b0;
    drive_b(5'd9, 32'hDEAD);
    @(negedge clk);
    check("b_ready_single", 32'(b_ready), 32'd1);
    check("a_ready_single_b", 32'(a_ready), 32'd0);
    expect_write(5'd9, 32'hDEAD);
    step();
    idle();

    // x0 write is consumed with no enable, then a normal write
    drive_a(5'd0, 32'hFFFF);
    @(negedge clk);
    check("a_ready_x0", 32'(a_ready), 32'd1);
    step();
    a_valid = 1'b0;
    drive_b(5'd3, 32'h5);
    @(negedge clk);
    check("b_ready_after_x0", 32'(b_ready), 32'd1);
    expect_write(5'd3, 32'h5);
    step();
    idle();
    @(negedge clk);
    check("idle_a_ready", 32'(a_ready), 32'd0);
    check("idle_b_ready", 32'(b_ready), 32'd0);
    step();

    // Fresh reset, then round-robin collisions: A, B, A, B
    clr = 1'b1;
    step();
    clr = 1'b0;
    drive_a(5'd1, 32'h11);
    drive_b(5'd2, 32'h22);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rr_cnt", 32'(collision_cnt), 32'(i));
      check("rr_a_ready", 32'(a_ready), (i % 2 == 0) ? 32'd1 : 32'd0);
      check("rr_b_ready", 32'(b_ready), (i % 2 == 1) ? 32'd1 : 32'd0);
      if (i % 2 == 0) expect_write(5'd1, 32'h11);
      else            expect_write(5'd2, 32'h22);
      step();
    end
    idle();
    @(negedge clk);
    check("rr_cnt_final", 32'(collision_cnt), 32'd4);
    step();

    // Flush with an in-flight write and A held valid across the flush
    drive_a(5'd5, 32'h9);
    @(negedge clk);
    check("fl_accept", 32'(a_ready), 32'd1);
    expect_write(5'd5, 32'h9);
    step();
    drive_a(5'd6, 32'hA);
    flush_req = 1'b1;
    @(negedge clk);
    check("fl_req_ready", 32'(a_ready), 32'd0);
    check("fl_req_busy", 32'(flush_busy), 32'd0);
    step();
    flush_req = 1'b1;
    @(negedge clk);
    check("fl_drain_busy", 32'(flush_busy), 32'd1);
    check("fl_drain_ready", 32'(a_ready), 32'd0);
    check("fl_drain_clr", 32'(rf_clr), 32'd0);
    step();
    flush_req = 1'b0;
    @(negedge clk);
    check("fl_clear_busy", 32'(flush_busy), 32'd1);
    check("fl_clear_clr", 32'(rf_clr), 32'd1);
    check("fl_clear_ready", 32'(a_ready), 32'd0);
    step();
    @(negedge clk);
    check("fl_resume_busy", 32'(flush_busy), 32'd0);
    check("fl_resume_clr", 32'(rf_clr), 32'd0);
    check("fl_resume_ready", 32'(a_ready), 32'd1);
    expect_write(5'd6, 32'hA);
    step();
    idle();
    @(negedge clk);
    check("fl_no_retrigger", 32'(flush_busy), 32'd0);
    check("fl_clr_once", 32'(rf_clr), 32'd0);
    step();

    // Collision (B wins after A), then reset asserted during DRAIN
    drive_a(5'd7, 32'h70);
    drive_b(5'd8, 32'h80);
    @(negedge clk);
    check("pre_rst_b_wins", 32'(b_ready), 32'd1);
    check("pre_rst_a_loses", 32'(a_ready), 32'd0);
    expect_write(5'd8, 32'h80);
    step();
    idle();
    flush_req = 1'b1;
    @(negedge clk);
    check("pre_rst_cnt", 32'(collision_cnt), 32'd5);
    step();
    flush_req = 1'b0;
    @(negedge clk);
    check("pre_rst_drain", 32'(flush_busy), 32'd1);
    #1;
    clr = 1'b1;
    #1;
    check("mid_rst_busy", 32'(flush_busy), 32'd0);
    check("mid_rst_we", 32'(rf_we), 32'd0);
    check("mid_rst_clr", 32'(rf_clr), 32'd0);
    check("mid_rst_waddr", 32'(rf_waddr), 32'd0);
    check("mid_rst_wdata", rf_wdata, 32'd0);
    check("mid_rst_cnt", 32'(collision_cnt), 32'd0);
    step();
    check("post_rst_clr", 32'(rf_clr), 32'd0);
    clr = 1'b0;

    // Saturation: 20 collision cycles, A first after reset, counter stops at 15
    drive_a(5'd7, 32'h70);
    drive_b(5'd8, 32'h80);
    exp_a = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("sat_a_ready", 32'(a_ready), 32'(exp_a));
      check("sat_b_ready", 32'(b_ready), 32'(!exp_a));
      check("sat_cnt", 32'(collision_cnt), (i > 15) ? 32'd15 : 32'(i));
      if (exp_a) expect_write(5'd7, 32'h70);
      else       expect_write(5'd8, 32'h80);
      exp_a = !exp_a;
      step();
    end
    idle();
    @(negedge clk);
    check("sat_cnt_final", 32'(collision_cnt), 32'd15);
    repeat (3) step();
    @(negedge clk);
    #1;
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
